// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg: shared definitions for the display arbiter slice.
//   - value width and display ceiling (3 decimal digits)
//   - source index constants (engine, entry)
//   - arbiter state encoding
//   - clamp helper producing the displayable value plus overflow flag
package disp_arbiter_pkg;

    localparam int unsigned VAL_W = 10;

    typedef logic [VAL_W-1:0] val_t;

    localparam val_t MAX_DISP = val_t'(999);

    // Source indices; also the bit positions in req/gnt.
    localparam logic SRC_ENGINE = 1'b0;
    localparam logic SRC_ENTRY  = 1'b1;

    // Arbiter state encoding.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;

    typedef struct packed {
        val_t bin;
        logic ovf;
    } disp_t;

    // Saturate a raw value to what three digits can show and flag the loss.
    function automatic disp_t clamp_val(input val_t v);
        disp_t r;
        if (v > MAX_DISP) begin
            r.bin = MAX_DISP;
            r.ovf = 1'b1;
        end else begin
            r.bin = v;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: bundle between the two value producers and the display arbiter.
//   req     - per-source request level (bit 0 engine, bit 1 entry)
//   val0    - engine value
//   val1    - entry value
//   gnt     - one-hot grant, 00 when idle
//   bin_out - clamped value of the current owner
//   ovf     - owner value exceeded the display range
//   tick    - refresh strobe for the digit multiplexer
// Modports: master = producer/consumer side, slave = arbiter side.
import disp_arbiter_pkg::*;

interface disp_arbiter_if;

    logic [1:0] req;
    val_t       val0;
    val_t       val1;
    logic [1:0] gnt;
    val_t       bin_out;
    logic       ovf;
    logic       tick;

    modport master (
        output req,
        output val0,
        output val1,
        input  gnt,
        input  bin_out,
        input  ovf,
        input  tick
    );

    modport slave (
        input  req,
        input  val0,
        input  val1,
        output gnt,
        output bin_out,
        output ovf,
        output tick
    );

endinterface

// File: rtl/disp_arbiter_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle strobe every DIV cycles.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - registered strobe, first pulse DIV cycles after reset release
// Parameter DIV (>= 2) sets the strobe period.
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        // Strobe is registered, so it appears in the cycle after the wrap point.
        tick_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the 3-digit display between the engine and entry paths.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of disp_arbiter_if (req/val0/val1 in; gnt/bin_out/ovf/tick out)
// Round-robin arbitration on ties, a minimum hold of HOLD refresh ticks before an
// owner can be pre-empted, clamping to 999 with an overflow flag, and the refresh
// strobe from an embedded prescaler of period DIV.
import disp_arbiter_pkg::*;

module disp_arbiter #(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned HOLD = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    disp_arbiter_if.slave  bus
);

    localparam int unsigned HOLD_W   = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD);

    logic              tick;

    logic              state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        gnt_q, gnt_d;
    val_t              bin_q, bin_d;
    logic              ovf_q, ovf_d;

    logic              other;
    val_t              owner_val;
    disp_t             owner_disp;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign other      = ~owner_q;
    assign owner_val  = (owner_q == SRC_ENTRY) ? bus.val1 : bus.val0;
    assign owner_disp = clamp_val(owner_val);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_OWN;
                    hold_d  = '0;
                    if (bus.req == 2'b11) begin
                        owner_d = rr_q;
                    end else begin
                        owner_d = bus.req[SRC_ENTRY];
                    end
                    // Loser of this grant is favoured on the next tie.
                    rr_d = ~owner_d;
                end
            end
            ST_OWN: begin
                bin_d = owner_disp.bin;
                ovf_d = owner_disp.ovf;
                // A drop wins over pre-emption; both give the same hand-over anyway.
                if (!bus.req[owner_q]) begin
                    if (bus.req[other]) begin
                        owner_d = other;
                        hold_d  = '0;
                        rr_d    = owner_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if ((hold_q == HOLD_MAX) && bus.req[other]) begin
                    owner_d = other;
                    hold_d  = '0;
                    rr_d    = owner_q;
                end else if (tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_d = 2'b00;
        if (state_d == ST_OWN) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= SRC_ENGINE;
            rr_q    <= SRC_ENGINE;
            hold_q  <= '0;
            gnt_q   <= 2'b00;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.bin_out = bin_q;
    assign bus.ovf     = ovf_q;
    assign bus.tick    = tick;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed self-checking bench for disp_arbiter with DIV=4, HOLD=2.
module tb_disp_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    disp_arbiter_if bus ();

    disp_arbiter #(
        .DIV  (4),
        .HOLD (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After this returns, the next rising edge is edge 1 after release.
    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.req  = 2'b00;
        bus.val0 = 10'd0;
        bus.val1 = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.req  = 2'b01;
        bus.val0 = 10'd345;
        step();
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_pre_gnt got %b want 01", bus.gnt);
        end
        checks++;
        repeat (3) step();
        // Edge 4: tick high, bin_out loaded.
        if (bus.tick !== 1'b1 || bus.bin_out !== 10'd345) begin
            errors++;
            $display("FAIL reset_pre_state tick %b bin %0d want 1 345", bus.tick, bus.bin_out);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if (bus.gnt !== 2'b00 || bus.bin_out !== 10'd0 || bus.ovf !== 1'b0 ||
            bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_async gnt %b bin %0d ovf %b tick %b want 00 0 0 0",
                     bus.gnt, bus.bin_out, bus.ovf, bus.tick);
        end
        checks++;
        bus.req = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL reset_tick_phase cycle %0d got %b want %b",
                         k, bus.tick, ((k % 4) == 0));
            end
            checks++;
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req  = 2'b01;
        bus.val0 = 10'd345;
        step();
        if (bus.gnt !== 2'b01 || bus.bin_out !== 10'd0) begin
            errors++;
            $display("FAIL single_gnt gnt %b bin %0d want 01 0", bus.gnt, bus.bin_out);
        end
        checks++;
        step();
        if (bus.bin_out !== 10'd345 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_data bin %0d ovf %b want 345 0", bus.bin_out, bus.ovf);
        end
        checks++;
        bus.req = 2'b00;
        step();
        if (bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_release gnt %b want 00", bus.gnt);
        end
        checks++;
        bus.val0 = 10'd7;
        step();
        if (bus.bin_out !== 10'd345 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_idle_hold bin %0d gnt %b want 345 00", bus.bin_out, bus.gnt);
        end
        checks++;
    endtask

    task automatic test_tie_rr();
        apply_reset();
        bus.req = 2'b11;
        step();
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL tie_first gnt %b want 01", bus.gnt);
        end
        checks++;
        bus.req = 2'b00;
        step();
        if (bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL tie_release gnt %b want 00", bus.gnt);
        end
        checks++;
        repeat (2) step();
        bus.req = 2'b11;
        step();
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL tie_rr gnt %b want 10", bus.gnt);
        end
        checks++;
    endtask

    // Ticks are seen by the hold counter at edges 5, 9, 13, 17 after release.
    task automatic test_preempt();
        apply_reset();
        bus.val0 = 10'd12;
        bus.val1 = 10'd700;
        bus.req  = 2'b01;
        step();
        bus.req = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step();
            if (bus.gnt !== 2'b01) begin
                errors++;
                $display("FAIL preempt_hold0 edge %0d gnt %b want 01", k, bus.gnt);
            end
            checks++;
        end
        step();
        if (bus.gnt !== 2'b10 || bus.bin_out !== 10'd12) begin
            errors++;
            $display("FAIL preempt_switch gnt %b bin %0d want 10 12", bus.gnt, bus.bin_out);
        end
        checks++;
        step();
        if (bus.bin_out !== 10'd700) begin
            errors++;
            $display("FAIL preempt_data bin %0d want 700", bus.bin_out);
        end
        checks++;
        for (int k = 12; k <= 17; k++) begin
            step();
            if (bus.gnt !== 2'b10) begin
                errors++;
                $display("FAIL preempt_hold1 edge %0d gnt %b want 10", k, bus.gnt);
            end
            checks++;
        end
        step();
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL preempt_back gnt %b want 01", bus.gnt);
        end
        checks++;
        step();
        if (bus.bin_out !== 10'd12) begin
            errors++;
            $display("FAIL preempt_back_data bin %0d want 12", bus.bin_out);
        end
        checks++;
    endtask

    task automatic test_clamp();
        apply_reset();
        bus.req  = 2'b01;
        bus.val0 = 10'd1023;
        repeat (2) step();
        if (bus.bin_out !== 10'd999 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL clamp_1023 bin %0d ovf %b want 999 1", bus.bin_out, bus.ovf);
        end
        checks++;
        bus.val0 = 10'd999;
        step();
        if (bus.bin_out !== 10'd999 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL clamp_999 bin %0d ovf %b want 999 0", bus.bin_out, bus.ovf);
        end
        checks++;
        bus.val0 = 10'd1000;
        step();
        if (bus.bin_out !== 10'd999 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL clamp_1000 bin %0d ovf %b want 999 1", bus.bin_out, bus.ovf);
        end
        checks++;
        bus.val0 = 10'd42;
        step();
        if (bus.bin_out !== 10'd42 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL clamp_42 bin %0d ovf %b want 42 0", bus.bin_out, bus.ovf);
        end
        checks++;
    endtask

    // Owner 0 drops during the tick that would complete its hold count.
    task automatic test_simul_release();
        apply_reset();
        bus.val0 = 10'd12;
        bus.val1 = 10'd700;
        bus.req  = 2'b01;
        step();
        bus.req = 2'b11;
        repeat (7) step();
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL simul_pre gnt %b want 01", bus.gnt);
        end
        checks++;
        bus.req = 2'b10;
        step();
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL simul_switch gnt %b want 10", bus.gnt);
        end
        checks++;
        bus.req = 2'b11;
        // Hold restarted at 0, so the hand-back waits for the ticks at edges 13 and 17.
        for (int k = 10; k <= 17; k++) begin
            step();
            if (bus.gnt !== 2'b10) begin
                errors++;
                $display("FAIL simul_hold edge %0d gnt %b want 10", k, bus.gnt);
            end
            checks++;
            if (k == 10 && bus.bin_out !== 10'd700) begin
                errors++;
                $display("FAIL simul_data bin %0d want 700", bus.bin_out);
            end
            if (k == 10) checks++;
        end
        step();
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL simul_back gnt %b want 01", bus.gnt);
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_single();
        test_tie_rr();
        test_preempt();
        test_clamp();
        test_simul_release();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
